// File: rtl/exe_op_scheduler.sv
// Round-robin scheduler sharing one execution datapath among N_REQ requesters.
// One operation in flight: grant, settle for EXE_LAT cycles, capture, respond.
module exe_op_scheduler #(
    parameter int BITS    = 8,
    parameter int N_REQ   = 4,
    parameter int OPW     = 4,
    parameter int EXE_LAT = 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [N_REQ-1:0]        i_req,
    input  logic [N_REQ*BITS-1:0]   i_argA,
    input  logic [N_REQ*BITS-1:0]   i_argB,
    input  logic [N_REQ*OPW-1:0]    i_op,
    output logic [N_REQ-1:0]        o_gnt,
    output logic [$clog2(N_REQ)-1:0] o_gnt_idx,
    output logic [BITS-1:0]         o_exe_argA,
    output logic [BITS-1:0]         o_exe_argB,
    output logic [OPW-1:0]          o_exe_op,
    input  logic [BITS-1:0]         i_exe_result,
    output logic                    o_rsp_valid,
    output logic [BITS-1:0]         o_result,
    input  logic                    i_rsp_ready,
    output logic                    o_busy
);
    localparam int IW = $clog2(N_REQ);
    localparam int CW = (EXE_LAT > 1) ? $clog2(EXE_LAT) : 1;
    localparam logic [N_REQ-1:0] GNT_ONE = {{(N_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [IW-1:0]     ptr_r;
    logic [CW-1:0]     cnt_r;
    logic [N_REQ-1:0]  gnt_r;
    logic [IW-1:0]     idx_r;
    logic [BITS-1:0]   arga_r;
    logic [BITS-1:0]   argb_r;
    logic [OPW-1:0]    op_r;
    logic              rsp_valid_r;
    logic [BITS-1:0]   result_r;
    logic              win_found_s;
    logic [IW-1:0]     win_idx_s;

    // Round-robin search starting just after the last served requester.
    always_comb begin
        int cand;
        cand        = 0;
        win_found_s = 1'b0;
        win_idx_s   = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = int'(ptr_r) + i;
            cand = (cand >= N_REQ) ? (cand - N_REQ) : cand;
            if (!win_found_s && i_req[cand]) begin
                win_found_s = 1'b1;
                win_idx_s   = IW'(cand);
            end else begin
                win_idx_s   = win_idx_s;
            end
        end
    end

    // Next-state logic; in RESP the valid is always high so ready alone completes the transfer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (win_found_s) state_nxt_s = ST_EXEC;
                else             state_nxt_s = ST_IDLE;
            end
            ST_EXEC: begin
                if (cnt_r == '0) state_nxt_s = ST_RESP;
                else             state_nxt_s = ST_EXEC;
            end
            ST_RESP: begin
                if (i_rsp_ready) state_nxt_s = ST_IDLE;
                else             state_nxt_s = ST_RESP;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_r <= ST_IDLE;
        else          state_r <= state_nxt_s;
    end

    // Grant, operand latch, settle counter, result capture and pointer update.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr_r       <= IW'(N_REQ - 1);
            cnt_r       <= '0;
            gnt_r       <= '0;
            idx_r       <= '0;
            arga_r      <= '0;
            argb_r      <= '0;
            op_r        <= '0;
            rsp_valid_r <= 1'b0;
            result_r    <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (win_found_s) begin
                        gnt_r  <= GNT_ONE << win_idx_s;
                        idx_r  <= win_idx_s;
                        arga_r <= i_argA[int'(win_idx_s)*BITS +: BITS];
                        argb_r <= i_argB[int'(win_idx_s)*BITS +: BITS];
                        op_r   <= i_op[int'(win_idx_s)*OPW +: OPW];
                        cnt_r  <= CW'(EXE_LAT - 1);
                    end
                end
                ST_EXEC: begin
                    if (cnt_r == '0) begin
                        result_r    <= i_exe_result;
                        rsp_valid_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r - CW'(1'b1);
                    end
                end
                ST_RESP: begin
                    if (i_rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        gnt_r       <= '0;
                        idx_r       <= '0;
                        ptr_r       <= idx_r;
                        arga_r      <= '0;
                        argb_r      <= '0;
                        op_r        <= '0;
                    end
                end
                default: begin
                    rsp_valid_r <= 1'b0;
                    gnt_r       <= '0;
                end
            endcase
        end
    end

    assign o_gnt       = gnt_r;
    assign o_gnt_idx   = idx_r;
    assign o_exe_argA  = arga_r;
    assign o_exe_argB  = argb_r;
    assign o_exe_op    = op_r;
    assign o_rsp_valid = rsp_valid_r;
    assign o_result    = result_r;
    assign o_busy      = (state_r != ST_IDLE);

endmodule
